// File: rtl/image_stream.sv
// Image-side transmitter: pulls pixel words from the image buffer and streams them to the
// layers block in windows of beat_nb beats, win_nb windows per run, through an output register plus skid.
//
// state | meaning
// IDLE  | waiting for start; configuration writes accepted
// RUN   | accepting upstream words, tagging the last beat of each window
// DRAIN | final word accepted; emptying skid and output register
// FIN   | run complete; done pulses on the following cycle
module image_stream #(
    parameter int                    CFG_DWIDTH = 32,
    parameter int                    CFG_AWIDTH = 5,
    parameter int                    GROUP_NB   = 4,
    parameter int                    IMG_WIDTH  = 16,
    parameter logic [CFG_AWIDTH-1:0] CFG_STREAM = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] src_bus,
    input  logic                          src_val,
    output logic                          src_rdy,
    output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    output logic                          image_last,
    output logic                          image_val,
    input  logic                          image_rdy
);

    localparam int BW = GROUP_NB * IMG_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_DRAIN = 4'b0100,
        S_FIN   = 4'b1000
    } state_t;

    state_t          state_q;
    logic [15:0]     beat_nb_q, win_nb_q;
    logic [15:0]     run_beat_q, run_win_q;
    logic [15:0]     beat_cnt_q, beat_cnt_d;
    logic [15:0]     win_cnt_q, win_cnt_d;
    logic            final_q, final_d;
    logic            src_rdy_q, busy_q, done_q;
    logic            out_val_q, out_val_d;
    logic            out_last_q, out_last_d;
    logic [BW-1:0]   out_data_q, out_data_d;
    logic            skid_full_q, skid_full_d;
    logic            skid_last_q, skid_last_d;
    logic [BW-1:0]   skid_data_q, skid_data_d;
    logic            up, last_tag, cfg_wr;

    assign cfg_wr = cfg_valid && (cfg_addr == CFG_STREAM) && (state_q == S_IDLE);

    always_comb begin
        up          = src_val & src_rdy_q;
        last_tag    = (beat_cnt_q == run_beat_q - 16'd1);
        beat_cnt_d  = beat_cnt_q;
        win_cnt_d   = win_cnt_q;
        final_d     = final_q;
        out_val_d   = out_val_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;

        if (up) begin
            if (last_tag) begin
                beat_cnt_d = '0;
                win_cnt_d  = win_cnt_q + 16'd1;
                if (win_cnt_q == run_win_q - 16'd1)
                    final_d = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 16'd1;
            end
        end

        // Output register frees up when empty or draining this cycle; skid always has priority.
        if (!out_val_q || image_rdy) begin
            if (skid_full_q) begin
                out_val_d   = 1'b1;
                out_data_d  = skid_data_q;
                out_last_d  = skid_last_q;
                skid_full_d = up;
                if (up) begin
                    skid_data_d = src_bus;
                    skid_last_d = last_tag;
                end
            end else begin
                out_val_d = up;
                if (up) begin
                    out_data_d = src_bus;
                    out_last_d = last_tag;
                end
            end
        end else if (up) begin
            skid_full_d = 1'b1;
            skid_data_d = src_bus;
            skid_last_d = last_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            beat_nb_q   <= '0;
            win_nb_q    <= '0;
            run_beat_q  <= '0;
            run_win_q   <= '0;
            beat_cnt_q  <= '0;
            win_cnt_q   <= '0;
            final_q     <= 1'b0;
            src_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_val_q   <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            win_cnt_q   <= win_cnt_d;
            final_q     <= final_d;
            out_val_q   <= out_val_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            done_q      <= (state_q == S_FIN);

            if (cfg_wr) begin
                beat_nb_q <= cfg_data[15:0];
                win_nb_q  <= cfg_data[31:16];
            end

            case (state_q)
                S_IDLE: begin
                    src_rdy_q <= 1'b0;
                    if (start) begin
                        // Snapshot the counts so a coincident cfg write only affects the next run.
                        run_beat_q <= beat_nb_q;
                        run_win_q  <= win_nb_q;
                        beat_cnt_q <= '0;
                        win_cnt_q  <= '0;
                        final_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        if (beat_nb_q == 16'd0 || win_nb_q == 16'd0) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q   <= S_RUN;
                            src_rdy_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (final_d) begin
                        state_q   <= S_DRAIN;
                        src_rdy_q <= 1'b0;
                    end else begin
                        src_rdy_q <= ~skid_full_d;
                    end
                end
                S_DRAIN: begin
                    src_rdy_q <= 1'b0;
                    if (!skid_full_d && !out_val_d)
                        state_q <= S_FIN;
                end
                S_FIN: begin
                    src_rdy_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    src_rdy_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign src_rdy    = src_rdy_q;
    assign image_val  = out_val_q;
    assign image_bus  = out_data_q;
    assign image_last = out_last_q;

endmodule

// File: tb/tb_image_stream.sv
// Randomized bench for image_stream: a FIFO-ordered scoreboard of accepted words plus
// window arithmetic (beat index mod beat_nb) predicts every downstream beat.
module tb_image_stream;

    localparam int         BW         = 64;
    localparam logic [4:0] CFG_STREAM = 5'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cfg_data = '0;
    logic [4:0]    cfg_addr = '0;
    logic          cfg_valid = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [BW-1:0] src_bus = '0;
    logic          src_val = 1'b0;
    logic          src_rdy;
    logic [BW-1:0] image_bus;
    logic          image_last, image_val;
    logic          image_rdy = 1'b0;

    image_stream #(
        .CFG_DWIDTH(32), .CFG_AWIDTH(5), .GROUP_NB(4), .IMG_WIDTH(16), .CFG_STREAM(CFG_STREAM)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .start(start), .busy(busy), .done(done),
        .src_bus(src_bus), .src_val(src_val), .src_rdy(src_rdy),
        .image_bus(image_bus), .image_last(image_last), .image_val(image_val),
        .image_rdy(image_rdy)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            mdl_bn  = 0;
    int            mdl_wn  = 0;
    logic [BW-1:0] cur_word;
    logic [BW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [4:0] addr, input int bn, input int wn);
        @(negedge clk);
        cfg_addr  = addr;
        cfg_data  = {wn[15:0], bn[15:0]};
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        if (addr == CFG_STREAM) begin
            mdl_bn = bn;
            mdl_wn = wn;
        end
    endtask

    // extra: 0 none, 1 cfg write coincident with start, 2 cfg write plus start mid-run
    task automatic run_stream(input int src_pct, input int rdy_pct, input int stall_at,
                              input int stall_len, input int extra, input int new_bn,
                              input int new_wn);
        int            bn, wn, total, rx, acc, done_it, last_it, gap;
        logic          prev_stall, prev_absorb, prev_last;
        logic [BW-1:0] prev_bus;
        bn = mdl_bn; wn = mdl_wn; total = bn * wn;
        rx = 0; acc = 0; done_it = -1; last_it = -1;
        prev_stall = 1'b0; prev_absorb = 1'b0; prev_last = 1'b0; prev_bus = '0;
        exp_q.delete();
        for (int it = 0; it < 3000 && done_it < 0; it++) begin
            @(negedge clk);
            start     = (it == 0) || (extra == 2 && it == 4);
            cfg_valid = (extra == 1 && it == 0) || (extra == 2 && it == 4);
            cfg_addr  = CFG_STREAM;
            cfg_data  = {new_wn[15:0], new_bn[15:0]};
            src_val   = ($urandom_range(99) < src_pct);
            src_bus   = cur_word;
            image_rdy = ($urandom_range(99) < rdy_pct) && !(it >= stall_at && it < stall_at + stall_len);
            #1;
            if (done) begin
                done_it = it;
                check_eq("busy_at_done", busy, 0);
            end else if (it > 0) begin
                check_eq("busy_in_run", busy, 1);
            end
            if (prev_stall) begin
                check_eq("stall_val", image_val, 1);
                check_eq("stall_bus", image_bus, prev_bus);
                check_eq("stall_last", image_last, prev_last);
            end
            if (prev_absorb)
                check_eq("src_rdy_drop", src_rdy, 0);
            prev_absorb = image_val && !image_rdy && src_val && src_rdy;
            if (src_val && src_rdy) begin
                exp_q.push_back(cur_word);
                acc++;
                cur_word = {$urandom, $urandom};
            end
            if (image_val && image_rdy) begin
                check_eq("beat_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    check_eq("beat_data", image_bus, exp_q.pop_front());
                check_eq("beat_last", image_last, (bn > 0) && (rx % bn == bn - 1));
                rx++;
                last_it = it;
            end
            prev_stall = image_val && !image_rdy;
            prev_bus   = image_bus;
            prev_last  = image_last;
        end
        start = 1'b0; cfg_valid = 1'b0; src_val = 1'b0;
        check_eq("done_seen", done_it >= 0, 1);
        check_eq("beats_out", rx, total);
        check_eq("words_in", acc, total);
        if (total > 0) begin
            gap = done_it - last_it;
            check_eq("done_lag", (gap >= 1) && (gap <= 2), 1);
        end else begin
            check_eq("zero_done_at", done_it, 2);
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("done_once", done, 0);
            check_eq("idle_val", image_val, 0);
        end
        if (extra == 1) begin
            mdl_bn = new_bn;
            mdl_wn = new_wn;
        end
    endtask

    initial begin
        cur_word = {$urandom, $urandom};
        #3 rst = 1'b0;
        #9;
        check_eq("rst_val", image_val, 0);
        check_eq("rst_last", image_last, 0);
        check_eq("rst_bus", image_bus, 0);
        check_eq("rst_src_rdy", src_rdy, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        cfg_write(CFG_STREAM, 3, 2);
        run_stream(100, 100, -1, 0, 0, 0, 0);
        cfg_write(CFG_STREAM, 4, 1);
        run_stream(100, 100, 4, 5, 0, 0, 0);
        cfg_write(CFG_STREAM, 2, 3);
        run_stream(50, 100, -1, 0, 0, 0, 0);
        cfg_write(CFG_STREAM, 5, 0);
        run_stream(100, 100, -1, 0, 0, 0, 0);

        cfg_write(CFG_STREAM, 3, 2);
        run_stream(100, 100, -1, 0, 2, 2, 1);
        run_stream(100, 100, -1, 0, 0, 0, 0);
        cfg_write(CFG_STREAM, 2, 1);
        run_stream(100, 100, -1, 0, 1, 3, 1);
        run_stream(80, 80, -1, 0, 0, 0, 0);
        cfg_write(5'd7, 6, 6);
        run_stream(100, 60, -1, 0, 0, 0, 0);

        for (int r = 0; r < 5; r++) begin
            cfg_write(CFG_STREAM, $urandom_range(5, 1), $urandom_range(3, 1));
            run_stream($urandom_range(100, 30), $urandom_range(100, 30), -1, 0, 0, 0, 0);
        end

        cfg_write(CFG_STREAM, 4, 2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; src_val = 1'b1; image_rdy = 1'b1; src_bus = cur_word;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_val", image_val, 0);
        check_eq("arst_src_rdy", src_rdy, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_bus", image_bus, 0);
        src_val = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_eq("arst_no_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        mdl_bn = 0; mdl_wn = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check_eq("post_rst_done", done, 0);
        end
        cfg_write(CFG_STREAM, 4, 1);
        run_stream(100, 70, -1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
